id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
Instruction Decode stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage. It holds the IF/ID pipeline register and decodes the instruction into control fields and an immediate. It resolves branches and jumps in ID, driving the PC redirect back to fetch, and registers the results into the ID/EX pipeline register. Register-file reads are external; rs1/rs2 data arrive already forwarded.

Parameters:
RESET_ADDR, 32'h00000000, PC value held in the IF/ID and ID/EX registers at reset

Ports:
i_clk  in  1  global clock
i_rst  in  1  asynchronous active-high reset
i_inst_valid  in  1  fetch presents a valid instruction this cycle
i_inst  in  32  instruction word from fetch
i_fetch_pc  in  32  PC of i_inst
i_stall  in  1  hazard-unit stall: hold IF/ID, bubble ID/EX
o_rs1_raddr  out  5  rs1 index of the IF/ID instruction
o_rs2_raddr  out  5  rs2 index of the IF/ID instruction
i_rs1_rdata  in  32  forwarded rs1 value
i_rs2_rdata  in  32  forwarded rs2 value
o_pc_redirect  out  1  taken branch/jump; override fetch PC
o_pc_redirect_target  out  32  redirect target
o_illegal  out  1  one-cycle pulse: unsupported opcode consumed
o_ex_valid  out  1  ID/EX holds a real instruction
o_ex_pc  out  32  instruction PC
o_ex_rs1_data  out  32  latched rs1 value
o_ex_rs2_data  out  32  latched rs2 value (store data)
o_ex_imm  out  32  sign-extended immediate
o_ex_rd  out  5  destination register
o_ex_alu_op  out  4  {funct7[5] (R-type and SRAI only, else 0), funct3}; ADD forced for load/store/AUIPC/LUI
o_ex_alu_src_imm  out  1  ALU B operand = imm
o_ex_alu_src_pc  out  1  ALU A operand = pc (AUIPC); LUI uses A=0 and is signalled via wb_sel
o_ex_mem_ren  out  1  load
o_ex_mem_wen  out  1  store
o_ex_mem_funct3  out  3  load/store size and sign
o_ex_reg_wen  out  1  writes rd
o_ex_wb_sel  out  2  0 ALU, 1 memory, 2 pc+4 (link), 3 imm (LUI)

Behaviour:
- Reset (async): IF/ID valid=0, inst=32'h00000013, pc=RESET_ADDR. All o_ex_* are 0 except o_ex_pc=RESET_ADDR. o_pc_redirect=0 and o_illegal=0 (both are combinational on an invalid IF/ID).
- IF/ID capture on each posedge:
  - !i_stall: valid <= i_inst_valid && !o_pc_redirect; inst and pc load unconditionally.
  - i_stall: hold all fields.
- An instruction presented while a redirect is asserted is wrong-path and is dropped.
- Decode is combinational from the IF/ID register. o_rs1_raddr and o_rs2_raddr are always inst[19:15] and inst[24:20].
- Immediates: I, S, B, U, J formats with standard RV32I sign extension. B and J immediates have bit 0 = 0.
- Redirect is combinational: o_pc_redirect = IF/ID valid && !i_stall && (JAL || JALR || taken branch).
  - Branch compare: BEQ/BNE equality; BLT/BGE signed; BLTU/BGEU unsigned, on i_rs1_rdata/i_rs2_rdata.
  - Target for branch/JAL = pc + imm (mod 2^32). Target for JALR = (rs1 + imm) & ~1.
  - The not-taken target value is don't-care.
  - Misaligned targets are not trapped.
- ID/EX update on each posedge:
  - i_stall: o_ex_valid <= 0 and all write/mem enables <= 0 (bubble).
  - Otherwise: latch decode results; o_ex_valid <= IF/ID valid && legal.
  - Branches pass as valid with reg_wen=0, mem enables=0.
  - JAL/JALR: reg_wen=1, wb_sel=2.
  - rd=x0 forces reg_wen=0.
  - FENCE, ECALL and EBREAK decode as NOP (valid, no writes).
- Illegal: opcode not in the RV32I base set, with IF/ID valid and !i_stall.
  - o_illegal=1 for that cycle.
  - ID/EX receives a bubble.
  - The instruction is consumed (IF/ID advances).
- Latency: 1 cycle from fetch to IF/ID, 1 cycle IF/ID to ID/EX. Redirect is in the same cycle the branch sits in IF/ID and not stalled.
- Simultaneous events:
  - stall + taken branch: no redirect until the stall drops.
  - redirect + i_inst_valid: the incoming instruction is dropped.
  - Reset mid-stall: all state clears immediately.

Test Plan:
- Reset asserted asynchronously mid-cycle → o_ex_valid=0, o_pc_redirect=0, o_rs1_raddr=0 (NOP), o_ex_pc=RESET_ADDR without waiting for a clock edge.
- Fetch ADDI x5,x0,-3 (32'hFFD00293) at pc 0x100 → next+1 cycle: o_ex_valid=1, o_ex_imm=32'hFFFFFFFD, o_ex_rd=5, reg_wen=1, alu_src_imm=1, wb_sel=0.
- BEQ at pc 0x200, imm -8, rs1=rs2=7 → o_pc_redirect=1, target 0x1F8. The instruction presented the same cycle never reaches ID/EX. With rs2=8 → no redirect.
- BLTU vs BLT with rs1=0xFFFFFFFF, rs2=1 → BLT taken, BLTU not taken. JALR rs1=0x1003, imm=2 → target 0x1004; o_ex_wb_sel=2.
- i_stall held 2 cycles with LW in IF/ID → o_ex_valid=0 both cycles; IF/ID unchanged. LW issues with mem_ren=1, funct3=2 the cycle after the stall drops.
- Opcode 7'b0000000 in IF/ID, not stalled → o_illegal pulses 1 cycle, o_ex_valid=0 next cycle. ADD with rd=x0 → o_ex_valid=1, reg_wen=0.

Source files
------------

// File: rtl/id_stage.sv
// RV32I instruction decode stage: IF/ID register, decode, branch/jump resolution, ID/EX register.
// Ports: fetch in (i_inst*), stall in, rs index out / forwarded data in, redirect out, illegal out, o_ex_* ID/EX bundle.
module id_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h00000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inst_valid,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_fetch_pc,
    input  logic        i_stall,
    output logic [4:0]  o_rs1_raddr,
    output logic [4:0]  o_rs2_raddr,
    input  logic [31:0] i_rs1_rdata,
    input  logic [31:0] i_rs2_rdata,
    output logic        o_pc_redirect,
    output logic [31:0] o_pc_redirect_target,
    output logic        o_illegal,
    output logic        o_ex_valid,
    output logic [31:0] o_ex_pc,
    output logic [31:0] o_ex_rs1_data,
    output logic [31:0] o_ex_rs2_data,
    output logic [31:0] o_ex_imm,
    output logic [4:0]  o_ex_rd,
    output logic [3:0]  o_ex_alu_op,
    output logic        o_ex_alu_src_imm,
    output logic        o_ex_alu_src_pc,
    output logic        o_ex_mem_ren,
    output logic        o_ex_mem_wen,
    output logic [2:0]  o_ex_mem_funct3,
    output logic        o_ex_reg_wen,
    output logic [1:0]  o_ex_wb_sel
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] f3;
    logic       f7b5;

    assign opcode      = if_inst[6:0];
    assign rd          = if_inst[11:7];
    assign f3          = if_inst[14:12];
    assign f7b5        = if_inst[30];
    assign o_rs1_raddr = if_inst[19:15];
    assign o_rs2_raddr = if_inst[24:20];

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_opimm, is_op, is_nop_class, legal;

    assign is_lui       = (opcode == OP_LUI);
    assign is_auipc     = (opcode == OP_AUIPC);
    assign is_jal       = (opcode == OP_JAL);
    assign is_jalr      = (opcode == OP_JALR);
    assign is_branch    = (opcode == OP_BRANCH);
    assign is_load      = (opcode == OP_LOAD);
    assign is_store     = (opcode == OP_STORE);
    assign is_opimm     = (opcode == OP_IMM);
    assign is_op        = (opcode == OP_REG);
    // FENCE and SYSTEM are accepted but retire without side effects
    assign is_nop_class = (opcode == OP_FENCE) || (opcode == OP_SYSTEM);
    assign legal = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                   is_load | is_store | is_opimm | is_op | is_nop_class;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{if_inst[31]}}, if_inst[31:20]};
    assign imm_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
    assign imm_b = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                    if_inst[30:25], if_inst[11:8], 1'b0};
    assign imm_u = {if_inst[31:12], 12'b0};
    assign imm_j = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                    if_inst[20], if_inst[30:21], 1'b0};

    logic [31:0] d_imm;
    logic [3:0]  d_alu_op;
    logic        d_src_imm, d_src_pc, d_ren, d_wen, d_wr;
    logic [1:0]  d_wb;

    always_comb begin
        d_imm     = 32'b0;
        d_alu_op  = {1'b0, f3};
        d_src_imm = 1'b0;
        d_src_pc  = 1'b0;
        d_ren     = 1'b0;
        d_wen     = 1'b0;
        d_wr      = 1'b0;
        d_wb      = 2'd0;
        unique case (1'b1)
            is_lui: begin
                d_imm = imm_u; d_alu_op = 4'd0;
                d_src_imm = 1'b1; d_wr = 1'b1; d_wb = 2'd3;
            end
            is_auipc: begin
                d_imm = imm_u; d_alu_op = 4'd0;
                d_src_imm = 1'b1; d_src_pc = 1'b1; d_wr = 1'b1;
            end
            is_jal: begin
                d_imm = imm_j; d_alu_op = 4'd0;
                d_wr = 1'b1; d_wb = 2'd2;
            end
            is_jalr: begin
                d_imm = imm_i; d_src_imm = 1'b1;
                d_wr = 1'b1; d_wb = 2'd2;
            end
            is_branch: d_imm = imm_b;
            is_load: begin
                d_imm = imm_i; d_alu_op = 4'd0; d_src_imm = 1'b1;
                d_ren = 1'b1; d_wr = 1'b1; d_wb = 2'd1;
            end
            is_store: begin
                d_imm = imm_s; d_alu_op = 4'd0;
                d_src_imm = 1'b1; d_wen = 1'b1;
            end
            is_opimm: begin
                d_imm = imm_i; d_src_imm = 1'b1; d_wr = 1'b1;
                // only SRAI carries funct7[5] among immediate ops
                d_alu_op = {(f3 == 3'b101) & f7b5, f3};
            end
            is_op: begin
                d_alu_op = {f7b5, f3}; d_wr = 1'b1;
            end
            default: ;
        endcase
    end

    logic taken;

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000: taken = (i_rs1_rdata == i_rs2_rdata);
            3'b001: taken = (i_rs1_rdata != i_rs2_rdata);
            3'b100: taken = ($signed(i_rs1_rdata) < $signed(i_rs2_rdata));
            3'b101: taken = ($signed(i_rs1_rdata) >= $signed(i_rs2_rdata));
            3'b110: taken = (i_rs1_rdata < i_rs2_rdata);
            3'b111: taken = (i_rs1_rdata >= i_rs2_rdata);
            default: taken = 1'b0;
        endcase
    end

    logic        active;
    logic        dec_valid;
    logic [31:0] jalr_sum;

    assign active    = if_valid & ~i_stall;
    assign dec_valid = if_valid & legal;
    assign jalr_sum  = i_rs1_rdata + d_imm;

    assign o_pc_redirect = active & (is_jal | is_jalr | (is_branch & taken));
    assign o_pc_redirect_target = is_jalr ? (jalr_sum & 32'hFFFFFFFE)
                                          : (if_pc + d_imm);
    assign o_illegal = active & ~legal;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            if_valid <= 1'b0;
            if_inst  <= NOP;
            if_pc    <= RESET_ADDR;
        end else if (!i_stall) begin
            // anything fetched alongside a redirect is wrong-path
            if_valid <= i_inst_valid & ~o_pc_redirect;
            if_inst  <= i_inst;
            if_pc    <= i_fetch_pc;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ex_valid       <= 1'b0;
            o_ex_pc          <= RESET_ADDR;
            o_ex_rs1_data    <= 32'b0;
            o_ex_rs2_data    <= 32'b0;
            o_ex_imm         <= 32'b0;
            o_ex_rd          <= 5'b0;
            o_ex_alu_op      <= 4'b0;
            o_ex_alu_src_imm <= 1'b0;
            o_ex_alu_src_pc  <= 1'b0;
            o_ex_mem_ren     <= 1'b0;
            o_ex_mem_wen     <= 1'b0;
            o_ex_mem_funct3  <= 3'b0;
            o_ex_reg_wen     <= 1'b0;
            o_ex_wb_sel      <= 2'b0;
        end else if (i_stall) begin
            o_ex_valid   <= 1'b0;
            o_ex_mem_ren <= 1'b0;
            o_ex_mem_wen <= 1'b0;
            o_ex_reg_wen <= 1'b0;
        end else begin
            o_ex_valid       <= dec_valid;
            o_ex_pc          <= if_pc;
            o_ex_rs1_data    <= i_rs1_rdata;
            o_ex_rs2_data    <= i_rs2_rdata;
            o_ex_imm         <= d_imm;
            o_ex_rd          <= rd;
            o_ex_alu_op      <= d_alu_op;
            o_ex_alu_src_imm <= d_src_imm;
            o_ex_alu_src_pc  <= d_src_pc;
            o_ex_mem_ren     <= dec_valid & d_ren;
            o_ex_mem_wen     <= dec_valid & d_wen;
            o_ex_mem_funct3  <= f3;
            o_ex_reg_wen     <= dec_valid & d_wr & (rd != 5'd0);
            o_ex_wb_sel      <= d_wb;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios plus randomized instructions
// checked against an encoder-driven reference model.
module tb_id_stage;

    localparam logic [31:0] RA = 32'h00000080;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_inst_valid;
    logic [31:0] i_inst;
    logic [31:0] i_fetch_pc;
    logic        i_stall;
    logic [4:0]  o_rs1_raddr;
    logic [4:0]  o_rs2_raddr;
    logic [31:0] i_rs1_rdata;
    logic [31:0] i_rs2_rdata;
    logic        o_pc_redirect;
    logic [31:0] o_pc_redirect_target;
    logic        o_illegal;
    logic        o_ex_valid;
    logic [31:0] o_ex_pc;
    logic [31:0] o_ex_rs1_data;
    logic [31:0] o_ex_rs2_data;
    logic [31:0] o_ex_imm;
    logic [4:0]  o_ex_rd;
    logic [3:0]  o_ex_alu_op;
    logic        o_ex_alu_src_imm;
    logic        o_ex_alu_src_pc;
    logic        o_ex_mem_ren;
    logic        o_ex_mem_wen;
    logic [2:0]  o_ex_mem_funct3;
    logic        o_ex_reg_wen;
    logic [1:0]  o_ex_wb_sel;

    int errors = 0;
    int checks = 0;

    id_stage #(.RESET_ADDR(RA)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_inst_valid(i_inst_valid), .i_inst(i_inst),
        .i_fetch_pc(i_fetch_pc), .i_stall(i_stall),
        .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr),
        .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata),
        .o_pc_redirect(o_pc_redirect),
        .o_pc_redirect_target(o_pc_redirect_target),
        .o_illegal(o_illegal), .o_ex_valid(o_ex_valid),
        .o_ex_pc(o_ex_pc), .o_ex_rs1_data(o_ex_rs1_data),
        .o_ex_rs2_data(o_ex_rs2_data), .o_ex_imm(o_ex_imm),
        .o_ex_rd(o_ex_rd), .o_ex_alu_op(o_ex_alu_op),
        .o_ex_alu_src_imm(o_ex_alu_src_imm),
        .o_ex_alu_src_pc(o_ex_alu_src_pc),
        .o_ex_mem_ren(o_ex_mem_ren), .o_ex_mem_wen(o_ex_mem_wen),
        .o_ex_mem_funct3(o_ex_mem_funct3),
        .o_ex_reg_wen(o_ex_reg_wen), .o_ex_wb_sel(o_ex_wb_sel)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        si;
        logic        sp;
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic        rw;
        logic [1:0]  wb;
    } ex_t;

    ex_t act;
    assign act = {o_ex_valid, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data,
                  o_ex_imm, o_ex_rd, o_ex_alu_op, o_ex_alu_src_imm,
                  o_ex_alu_src_pc, o_ex_mem_ren, o_ex_mem_wen,
                  o_ex_mem_funct3, o_ex_reg_wen, o_ex_wb_sel};

    function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] r1,
                                          logic [2:0] f3, logic [4:0] rd,
                                          logic [6:0] op);
        return {im, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] im, logic [4:0] r2,
                                          logic [4:0] r1, logic [2:0] f3);
        return {im[11:5], r2, r1, f3, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:0] im, logic [4:0] r2,
                                          logic [4:0] r1, logic [2:0] f3);
        return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:0] im, logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
    endfunction

    task automatic fetch(input logic [31:0] inst, input logic [31:0] pc);
        i_inst_valid = 1'b1;
        i_inst       = inst;
        i_fetch_pc   = pc;
        @(posedge i_clk);
        #1;
        i_inst_valid = 1'b0;
    endtask

    task automatic test_reset();
        fetch(enc_i(12'd1, 5'd2, 3'd0, 5'd5, 7'h13), 32'h40);
        fetch(enc_b(13'd16, 5'd3, 5'd3, 3'd0), 32'h44);
        i_rs1_rdata = 32'd5;
        i_rs2_rdata = 32'd5;
        #2;
        i_stall = 1'b1;
        i_rst   = 1'b1;
        #1;
        checks++;
        if (o_ex_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ex_valid got=%b exp=0", o_ex_valid);
        end
        checks++;
        if (o_pc_redirect !== 1'b0) begin
            errors++; $display("FAIL reset_redirect got=%b exp=0", o_pc_redirect);
        end
        checks++;
        if (o_rs1_raddr !== 5'd0) begin
            errors++; $display("FAIL reset_rs1_raddr got=%0d exp=0", o_rs1_raddr);
        end
        checks++;
        if (o_ex_pc !== RA) begin
            errors++; $display("FAIL reset_ex_pc got=%h exp=%h", o_ex_pc, RA);
        end
        checks++;
        if ({o_illegal, o_ex_reg_wen} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ill_wen got=%b%b exp=00", o_illegal, o_ex_reg_wen);
        end
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_stall = 1'b0;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_ex_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_valid got=%b exp=0", o_ex_valid);
        end
    endtask

    task automatic test_addi();
        fetch(32'hFFD00293, 32'h100);
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_ex_valid, o_ex_reg_wen, o_ex_alu_src_imm} !== 3'b111) begin
            errors++;
            $display("FAIL addi_flags got=%b%b%b exp=111",
                     o_ex_valid, o_ex_reg_wen, o_ex_alu_src_imm);
        end
        checks++;
        if (o_ex_imm !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL addi_imm got=%h exp=fffffffd", o_ex_imm);
        end
        checks++;
        if ({o_ex_rd, o_ex_wb_sel} !== {5'd5, 2'd0}) begin
            errors++;
            $display("FAIL addi_rd_wb got=%0d/%0d exp=5/0", o_ex_rd, o_ex_wb_sel);
        end
        checks++;
        if (o_ex_pc !== 32'h100) begin
            errors++; $display("FAIL addi_pc got=%h exp=100", o_ex_pc);
        end
    endtask

    task automatic test_branch();
        logic [31:0] im;
        im = -32'sd8;
        fetch(enc_b(im[12:0], 5'd2, 5'd1, 3'd0), 32'h200);
        i_rs1_rdata  = 32'd7;
        i_rs2_rdata  = 32'd7;
        i_inst_valid = 1'b1;
        i_inst       = enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'h13);
        i_fetch_pc   = 32'h204;
        #1;
        checks++;
        if (o_pc_redirect !== 1'b1) begin
            errors++; $display("FAIL beq_redirect got=%b exp=1", o_pc_redirect);
        end
        checks++;
        if (o_pc_redirect_target !== 32'h1F8) begin
            errors++;
            $display("FAIL beq_target got=%h exp=1f8", o_pc_redirect_target);
        end
        @(posedge i_clk);
        #1;
        i_inst_valid = 1'b0;
        checks++;
        if ({o_ex_valid, o_ex_reg_wen, o_ex_mem_ren, o_ex_mem_wen} !== 4'b1000) begin
            errors++;
            $display("FAIL beq_ex got=%b%b%b%b exp=1000", o_ex_valid,
                     o_ex_reg_wen, o_ex_mem_ren, o_ex_mem_wen);
        end
        @(posedge i_clk);
        #1;
        checks++;
        if (o_ex_valid !== 1'b0) begin
            errors++; $display("FAIL wrong_path_drop got=%b exp=0", o_ex_valid);
        end
        fetch(enc_b(im[12:0], 5'd2, 5'd1, 3'd0), 32'h200);
        i_rs2_rdata = 32'd8;
        #1;
        checks++;
        if (o_pc_redirect !== 1'b0) begin
            errors++; $display("FAIL beq_not_taken got=%b exp=0", o_pc_redirect);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_compare();
        fetch(enc_b(13'd16, 5'd2, 5'd1, 3'd4), 32'h300);
        i_rs1_rdata = 32'hFFFFFFFF;
        i_rs2_rdata = 32'd1;
        #1;
        checks++;
        if ({o_pc_redirect, o_pc_redirect_target} !== {1'b1, 32'h310}) begin
            errors++;
            $display("FAIL blt_taken got=%b/%h exp=1/310",
                     o_pc_redirect, o_pc_redirect_target);
        end
        @(posedge i_clk);
        #1;
        fetch(enc_b(13'd16, 5'd2, 5'd1, 3'd6), 32'h340);
        #1;
        checks++;
        if (o_pc_redirect !== 1'b0) begin
            errors++; $display("FAIL bltu_not_taken got=%b exp=0", o_pc_redirect);
        end
        @(posedge i_clk);
        #1;
        fetch(enc_i(12'd2, 5'd3, 3'd0, 5'd1, 7'h67), 32'h400);
        i_rs1_rdata = 32'h1003;
        #1;
        checks++;
        if ({o_pc_redirect, o_pc_redirect_target} !== {1'b1, 32'h1004}) begin
            errors++;
            $display("FAIL jalr_target got=%b/%h exp=1/1004",
                     o_pc_redirect, o_pc_redirect_target);
        end
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_ex_valid, o_ex_reg_wen, o_ex_wb_sel} !== 4'b1110) begin
            errors++;
            $display("FAIL jalr_ex got=%b%b/%0d exp=11/2",
                     o_ex_valid, o_ex_reg_wen, o_ex_wb_sel);
        end
    endtask

    task automatic test_stall();
        fetch(enc_i(12'd4, 5'd1, 3'd2, 5'd9, 7'h03), 32'h500);
        i_stall      = 1'b1;
        i_inst_valid = 1'b1;
        i_inst       = enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'h13);
        i_fetch_pc   = 32'h504;
        for (int c = 0; c < 2; c++) begin
            @(posedge i_clk);
            #1;
            checks++;
            if ({o_ex_valid, o_ex_mem_ren} !== 2'b00) begin
                errors++;
                $display("FAIL stall_bubble[%0d] got=%b%b exp=00",
                         c, o_ex_valid, o_ex_mem_ren);
            end
            checks++;
            if ({o_rs1_raddr, o_rs2_raddr} !== {5'd1, 5'd4}) begin
                errors++;
                $display("FAIL stall_hold[%0d] got=%0d/%0d exp=1/4",
                         c, o_rs1_raddr, o_rs2_raddr);
            end
        end
        i_stall      = 1'b0;
        i_inst_valid = 1'b0;
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_ex_valid, o_ex_mem_ren, o_ex_mem_funct3, o_ex_wb_sel}
            !== {1'b1, 1'b1, 3'd2, 2'd1} || o_ex_pc !== 32'h500) begin
            errors++;
            $display("FAIL lw_issue got=%b%b/%0d/%0d pc=%h exp=11/2/1 pc=500",
                     o_ex_valid, o_ex_mem_ren, o_ex_mem_funct3,
                     o_ex_wb_sel, o_ex_pc);
        end
        fetch(enc_b(13'd8, 5'd2, 5'd1, 3'd0), 32'h600);
        i_rs1_rdata = 32'd3;
        i_rs2_rdata = 32'd3;
        i_stall     = 1'b1;
        #1;
        checks++;
        if (o_pc_redirect !== 1'b0) begin
            errors++; $display("FAIL stall_branch got=%b exp=0", o_pc_redirect);
        end
        @(posedge i_clk);
        #1;
        i_stall = 1'b0;
        #1;
        checks++;
        if ({o_pc_redirect, o_pc_redirect_target} !== {1'b1, 32'h608}) begin
            errors++;
            $display("FAIL unstall_branch got=%b/%h exp=1/608",
                     o_pc_redirect, o_pc_redirect_target);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_illegal();
        fetch(32'h00000000, 32'h700);
        checks++;
        if (o_illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_pulse got=%b exp=1", o_illegal);
        end
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_illegal, o_ex_valid} !== 2'b00) begin
            errors++;
            $display("FAIL illegal_after got=%b%b exp=00", o_illegal, o_ex_valid);
        end
        fetch({7'd0, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33}, 32'h704);
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_ex_valid, o_ex_reg_wen} !== 2'b10) begin
            errors++;
            $display("FAIL add_x0 got=%b%b exp=10", o_ex_valid, o_ex_reg_wen);
        end
    endtask

    task automatic test_random(input int n);
        logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int k = 0; k < n; k++) begin
            int kind;
            int im;
            logic [31:0] rnd, imm, a, b, pc, inst, tgt;
            logic [4:0] rd, r1, r2, sh;
            logic [2:0] f3;
            logic [6:0] opc;
            logic sra, red, ill, c1, c2, tk;
            ex_t e, m;
            kind = $urandom_range(0, 9);
            rnd = $urandom;
            rd = rnd[4:0]; r1 = rnd[9:5]; r2 = rnd[14:10];
            sh = rnd[19:15]; sra = rnd[20];
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            pc = $urandom & 32'hFFFFFFFC;
            im = int'($urandom_range(0, 4095)) - 2048;
            imm = im;
            f3 = 3'd0;
            red = 1'b0; ill = 1'b0; c1 = 1'b0; c2 = 1'b0; tgt = 32'd0;
            e = '0;
            m = '1;
            m.f3 = 3'd0;
            e.v = 1'b1; e.pc = pc; e.rs1 = a; e.rs2 = b; e.rd = rd;
            case (kind)
                0: begin
                    imm = $urandom & 32'hFFFFF000;
                    inst = {imm[31:12], rd, 7'h37};
                    e.imm = imm; e.rw = (rd != 0); e.wb = 2'd3;
                    m.si = 1'b0;
                end
                1: begin
                    imm = $urandom & 32'hFFFFF000;
                    inst = {imm[31:12], rd, 7'h17};
                    e.imm = imm; e.si = 1'b1; e.sp = 1'b1;
                    e.rw = (rd != 0);
                end
                2: begin
                    im = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                    imm = im;
                    inst = enc_j(imm[20:0], rd);
                    e.imm = imm; e.rw = (rd != 0); e.wb = 2'd2;
                    red = 1'b1; tgt = pc + imm;
                    m.op = '0; m.si = 1'b0;
                end
                3: begin
                    inst = enc_i(imm[11:0], r1, 3'd0, rd, 7'h67);
                    e.imm = imm; e.rw = (rd != 0); e.wb = 2'd2;
                    red = 1'b1; tgt = (a + imm) & 32'hFFFFFFFE;
                    m.op = '0; m.si = 1'b0; c1 = 1'b1;
                end
                4: begin
                    f3 = br_f3[$urandom_range(0, 5)];
                    im = im * 2;
                    imm = im;
                    inst = enc_b(imm[12:0], r2, r1, f3);
                    case (f3)
                        3'd0: tk = (a == b);
                        3'd1: tk = (a != b);
                        3'd4: tk = ($signed(a) < $signed(b));
                        3'd5: tk = ($signed(a) >= $signed(b));
                        3'd6: tk = (a < b);
                        default: tk = (a >= b);
                    endcase
                    e.imm = imm;
                    red = tk; tgt = pc + imm;
                    m.rd = '0; m.op = '0; m.si = 1'b0; m.sp = 1'b0; m.wb = '0;
                    c1 = 1'b1; c2 = 1'b1;
                end
                5: begin
                    f3 = ld_f3[$urandom_range(0, 4)];
                    inst = enc_i(imm[11:0], r1, f3, rd, 7'h03);
                    e.imm = imm; e.si = 1'b1; e.ren = 1'b1;
                    e.f3 = f3; m.f3 = '1;
                    e.rw = (rd != 0); e.wb = 2'd1; c1 = 1'b1;
                end
                6: begin
                    f3 = ld_f3[$urandom_range(0, 2)];
                    inst = enc_s(imm[11:0], r2, r1, f3);
                    e.imm = imm; e.si = 1'b1; e.wen = 1'b1;
                    e.f3 = f3; m.f3 = '1;
                    m.rd = '0; m.wb = '0; c1 = 1'b1; c2 = 1'b1;
                end
                7: begin
                    f3 = rnd[23:21];
                    if (f3 == 3'd1) imm = {27'd0, sh};
                    else if (f3 == 3'd5) imm = {21'd0, sra, 5'd0, sh};
                    inst = enc_i(imm[11:0], r1, f3, rd, 7'h13);
                    e.imm = imm; e.si = 1'b1; e.rw = (rd != 0);
                    e.op = {(f3 == 3'd5) && sra, f3}; c1 = 1'b1;
                end
                8: begin
                    f3 = rnd[23:21];
                    if (f3 != 3'd0 && f3 != 3'd5) sra = 1'b0;
                    inst = {1'b0, sra, 5'd0, r2, r1, f3, rd, 7'h33};
                    e.op = {sra, f3}; e.rw = (rd != 0);
                    m.imm = '0; c1 = 1'b1; c2 = 1'b1;
                end
                default: begin
                    do begin
                        opc = 7'($urandom_range(0, 127));
                    end while (opc inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                                           7'h03, 7'h23, 7'h13, 7'h33, 7'h0f,
                                           7'h73});
                    rnd = $urandom;
                    inst = {rnd[31:7], opc};
                    ill = 1'b1;
                    e = '0;
                    m = '0;
                    m.v = 1'b1; m.ren = 1'b1; m.wen = 1'b1; m.rw = 1'b1;
                end
            endcase
            fetch(inst, pc);
            i_inst = $urandom;
            i_rs1_rdata = a;
            i_rs2_rdata = b;
            #1;
            checks++;
            if (o_pc_redirect !== red || o_illegal !== ill ||
                (red && o_pc_redirect_target !== tgt) ||
                (c1 && o_rs1_raddr !== r1) || (c2 && o_rs2_raddr !== r2)) begin
                errors++;
                $display("FAIL rand_id[%0d] kind=%0d redir=%b/%h ill=%b rs=%0d/%0d exp redir=%b/%h ill=%b rs=%0d/%0d",
                         k, kind, o_pc_redirect, o_pc_redirect_target,
                         o_illegal, o_rs1_raddr, o_rs2_raddr,
                         red, tgt, ill, r1, r2);
            end
            @(posedge i_clk);
            #1;
            checks++;
            if ((act & m) !== (e & m)) begin
                errors++;
                $display("FAIL rand_ex[%0d] kind=%0d got=%h exp=%h mask=%h",
                         k, kind, act, e, m);
            end
        end
    endtask

    initial begin
        i_rst        = 1'b1;
        i_inst_valid = 1'b0;
        i_inst       = 32'h00000013;
        i_fetch_pc   = 32'd0;
        i_stall      = 1'b0;
        i_rs1_rdata  = 32'd0;
        i_rs2_rdata  = 32'd0;
        #12;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        test_reset();
        test_addi();
        test_branch();
        test_compare();
        test_stall();
        test_illegal();
        test_random(300);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
